// File: rtl/data_pipe.sv
// ============================================================================
// data_pipe : enable-gated, valid-tagged delay line with flush and occupancy
// Rev 1.0
// ============================================================================
`default_nettype none

module data_pipe #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;

    // Modular CW-bit arithmetic: a transient wrap on +1 is undone by the -1.
    assign w_count_next = r_count + CW'(valid_in) - CW'(r_valid[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
            r_count <= '0;
        end else if (flush) begin
            // Data registers intentionally keep their contents.
            r_valid <= '0;
            r_count <= '0;
        end else if (enable) begin
            r_data[0]  <= data_in;
            r_valid[0] <= valid_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
            r_count <= w_count_next;
        end
    end

    assign data_out  = r_data[DEPTH-1];
    assign valid_out = r_valid[DEPTH-1];
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_data_pipe.sv
// ============================================================================
// tb_data_pipe : scoreboard bench driving DEPTH=3 and DEPTH=1 builds in lockstep
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_pipe;

    localparam int WIDTH = 4;
    localparam int D3    = 3;

    typedef logic [WIDTH:0] ent_t;   // {valid, data}

    logic             clk = 1'b0;
    logic             reset, enable, flush, valid_in;
    logic [WIDTH-1:0] data_in;
    logic             valid_out3, valid_out1;
    logic [WIDTH-1:0] data_out3, data_out1;
    logic [1:0]       count3;
    logic [0:0]       count1;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t q3[$];            // entries still in flight behind the output stage
    ent_t last3, last1;     // expected contents of the output stage

    always #5 clk = ~clk;

    data_pipe #(.WIDTH(WIDTH), .DEPTH(D3)) u_dut3 (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out3), .data_out(data_out3), .count(count3)
    );

    data_pipe #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .valid_in(valid_in), .data_in(data_in),
        .valid_out(valid_out1), .data_out(data_out1), .count(count1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, advance the scoreboard, then compare both builds.
    task automatic cyc(input logic r, input logic e, input logic f,
                       input logic v, input logic [WIDTH-1:0] d);
        int cnt;
        reset = r; enable = e; flush = f; valid_in = v; data_in = d;
        @(posedge clk);
        #1;
        if (r) begin
            q3.delete();
            for (int i = 0; i < D3 - 1; i++) q3.push_back('0);
            last3 = '0;
            last1 = '0;
        end else if (f) begin
            foreach (q3[i]) q3[i][WIDTH] = 1'b0;
            last3[WIDTH] = 1'b0;
            last1[WIDTH] = 1'b0;
        end else if (e) begin
            q3.push_back({v, d});
            last3 = q3.pop_front();
            last1 = {v, d};
        end
        cnt = int'(last3[WIDTH]);
        foreach (q3[i]) cnt += int'(q3[i][WIDTH]);
        check_eq("d3_valid", 32'(valid_out3), 32'(last3[WIDTH]));
        check_eq("d3_data",  32'(data_out3),  32'(last3[WIDTH-1:0]));
        check_eq("d3_count", 32'(count3),     32'(cnt));
        check_eq("d1_valid", 32'(valid_out1), 32'(last1[WIDTH]));
        check_eq("d1_data",  32'(data_out1),  32'(last1[WIDTH-1:0]));
        check_eq("d1_count", 32'(count1),     32'(last1[WIDTH]));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0;
        last3 = '0; last1 = '0;
        #2;

        // Reset held with live-looking inputs.
        cyc(1, 1, 0, 1, 4'hF);
        cyc(1, 1, 0, 1, 4'hF);
        check_eq("rst_count", 32'(count3), 32'd0);

        // Streaming 1..7.
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 1, 0, 1, 4'(i));
            if (i == 3) check_eq("stream_first", 32'(data_out3), 32'd1);
        end
        check_eq("stream_full", 32'(count3), 32'd3);

        // Empty via flush without enable, then stall test.
        cyc(0, 0, 1, 0, 4'h0);
        check_eq("flush_hold_cnt", 32'(count3), 32'd0);
        for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 1, 4'(i));
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 4'h9);
        check_eq("stall_data", 32'(data_out3), 32'd1);
        check_eq("stall_cnt",  32'(count3),    32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 4'h0);

        // Bubbles 5,(6),7.
        cyc(0, 1, 0, 1, 4'h5);
        cyc(0, 1, 0, 0, 4'h6);
        cyc(0, 1, 0, 1, 4'h7);
        check_eq("bubble_peak", 32'(count3), 32'd2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 4'h0);

        // Flush together with enable: sample 8 is lost.
        for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 1, 4'(i));
        cyc(0, 1, 1, 1, 4'h8);
        check_eq("flush_en_valid", 32'(valid_out3), 32'd0);
        check_eq("flush_en_cnt",   32'(count3),     32'd0);
        cyc(0, 1, 0, 1, 4'h4);
        cyc(0, 1, 0, 0, 4'h0);
        cyc(0, 1, 0, 0, 4'h0);
        check_eq("post_flush_out", 32'({valid_out3, data_out3}), 32'h14);

        // Reset mid-stream, then a fresh sample.
        cyc(0, 1, 0, 1, 4'h1);
        cyc(0, 1, 0, 1, 4'h2);
        cyc(1, 1, 0, 1, 4'h3);
        check_eq("midrst_cnt1", 32'(count1), 32'd0);
        cyc(0, 1, 0, 1, 4'hA);
        check_eq("midrst_d1_out", 32'({valid_out1, data_out1}), 32'h1A);

        // Random mix of stall, flush, bubbles and rare resets.
        for (int i = 0; i < 200; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 11) == 0), 1'($urandom), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
